// File: rtl/pe_feeder_pkg.sv
// Shared constants and FSM encoding for the PE feeder and its PE_m integration.
package pe_feeder_pkg;

  localparam int CELL_BIT = 8;   // bits per cell
  localparam int N_CELL   = 9;   // cells per window beat
  localparam int OUT_BIT  = 8;   // PE result width
  localparam int STEP_W   = 3;   // beats-per-job-minus-one field width
  localparam int BOUND_W  = 3;   // bound level field width

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FEED = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/pe_feeder.sv
// Accepts a job command, streams step+1 window beats into a PE, waits for the
// PE result and holds it on a valid/ready response port.
module pe_feeder #(
  parameter int CELL_BIT = pe_feeder_pkg::CELL_BIT,
  parameter int N_CELL   = pe_feeder_pkg::N_CELL,
  parameter int OUT_BIT  = pe_feeder_pkg::OUT_BIT
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic [pe_feeder_pkg::STEP_W-1:0]    cmd_step,
  input  logic [pe_feeder_pkg::BOUND_W-1:0]   cmd_bound,
  input  logic                                dat_valid,
  output logic                                dat_ready,
  input  logic [CELL_BIT*N_CELL-1:0]          dat_in,
  input  logic [CELL_BIT*N_CELL-1:0]          dat_weight,
  output logic [CELL_BIT*N_CELL-1:0]          pe_in,
  output logic [CELL_BIT*N_CELL-1:0]          pe_weight,
  output logic                                pe_en,
  output logic [pe_feeder_pkg::STEP_W-1:0]    pe_step,
  output logic [pe_feeder_pkg::BOUND_W-1:0]   pe_bound_level,
  input  logic [OUT_BIT-1:0]                  pe_out,
  input  logic                                pe_out_en,
  output logic                                res_valid,
  input  logic                                res_ready,
  output logic [OUT_BIT-1:0]                  res_data,
  output logic                                busy,
  output logic                                err_stray
);

  import pe_feeder_pkg::*;

  state_t                      r_state;
  state_t                      w_next;
  logic [STEP_W-1:0]           r_step;
  logic [BOUND_W-1:0]          r_bound;
  logic [STEP_W-1:0]           r_cnt;
  logic [CELL_BIT*N_CELL-1:0]  r_pe_in;
  logic [CELL_BIT*N_CELL-1:0]  r_pe_weight;
  logic                        r_pe_en;
  logic                        r_res_valid;
  logic [OUT_BIT-1:0]          r_res_data;
  logic                        r_err_stray;

  logic w_accept_cmd;
  logic w_beat;
  logic w_last_beat;
  logic w_capture;
  logic w_release;
  logic w_stray;

  assign w_accept_cmd = (r_state == ST_IDLE) && cmd_valid;
  assign w_beat       = (r_state == ST_FEED) && dat_valid;
  assign w_last_beat  = w_beat && (r_cnt == r_step);
  assign w_capture    = (r_state == ST_WAIT) && pe_out_en;
  assign w_release    = (r_state == ST_RESP) && res_ready;
  // A PE result outside WAIT has no job to belong to.
  assign w_stray      = pe_out_en && (r_state != ST_WAIT);

  // Handshake readies and busy are decoded straight from the state.
  assign cmd_ready = (r_state == ST_IDLE);
  assign dat_ready = (r_state == ST_FEED);
  assign busy      = (r_state != ST_IDLE);

  assign pe_in          = r_pe_in;
  assign pe_weight      = r_pe_weight;
  assign pe_en          = r_pe_en;
  assign pe_step        = r_step;
  assign pe_bound_level = r_bound;
  assign res_valid      = r_res_valid;
  assign res_data       = r_res_data;
  assign err_stray      = r_err_stray;

  // State register.
  // NOTE: every clocked assignment is non-blocking so all registers update from
  // the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  // NOTE: w_next gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_accept_cmd) w_next = ST_FEED;
      ST_FEED: if (w_last_beat)  w_next = ST_WAIT;
      ST_WAIT: if (w_capture)    w_next = ST_RESP;
      ST_RESP: if (w_release)    w_next = ST_IDLE;
      default:                   w_next = ST_IDLE;
    endcase
  end

  // Job parameters, beat counter and PE-side datapath.
  // NOTE: the window registers are wide but still get a reset, so the PE never
  // sees stale cells from a dropped job after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_step      <= '0;
      r_bound     <= '0;
      r_cnt       <= '0;
      r_pe_in     <= '0;
      r_pe_weight <= '0;
      r_pe_en     <= 1'b0;
    end else begin
      r_pe_en <= w_beat;
      if (w_accept_cmd) begin
        r_step  <= cmd_step;
        r_bound <= cmd_bound;
        r_cnt   <= '0;
      end
      if (w_beat) begin
        r_pe_in     <= dat_in;
        r_pe_weight <= dat_weight;
        r_cnt       <= r_cnt + 1'b1;
      end
    end
  end

  // Result capture, response handshake and sticky stray flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_err_stray <= 1'b0;
    end else begin
      if (w_capture) begin
        r_res_data  <= pe_out;
        r_res_valid <= 1'b1;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
      // A stray arriving on the accept cycle is still reported.
      if (w_stray)           r_err_stray <= 1'b1;
      else if (w_accept_cmd) r_err_stray <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pe_feeder.sv
// Directed bench for pe_feeder with a small behavioural PE that accumulates
// signed dot products and answers two cycles after the final pe_en pulse.
module tb_pe_feeder;

  localparam int CB = 8;
  localparam int NC = 9;
  localparam int OB = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [2:0]        cmd_step = '0;
  logic [2:0]        cmd_bound = '0;
  logic              dat_valid = 1'b0;
  logic              dat_ready;
  logic [CB*NC-1:0]  dat_in = '0;
  logic [CB*NC-1:0]  dat_weight = '0;
  logic [CB*NC-1:0]  pe_in;
  logic [CB*NC-1:0]  pe_weight;
  logic              pe_en;
  logic [2:0]        pe_step;
  logic [2:0]        pe_bound_level;
  logic [OB-1:0]     pe_out;
  logic              pe_out_en;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic [OB-1:0]     res_data;
  logic              busy;
  logic              err_stray;

  int total = 0;
  int bad   = 0;
  int lat;

  always #5 clk = ~clk;

  pe_feeder dut (
    .clk            (clk),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_step       (cmd_step),
    .cmd_bound      (cmd_bound),
    .dat_valid      (dat_valid),
    .dat_ready      (dat_ready),
    .dat_in         (dat_in),
    .dat_weight     (dat_weight),
    .pe_in          (pe_in),
    .pe_weight      (pe_weight),
    .pe_en          (pe_en),
    .pe_step        (pe_step),
    .pe_bound_level (pe_bound_level),
    .pe_out         (pe_out),
    .pe_out_en      (pe_out_en),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .res_data       (res_data),
    .busy           (busy),
    .err_stray      (err_stray)
  );

  // ---------------- behavioural PE ----------------
  logic          inj = 1'b0;
  int            m_acc;
  int            m_val;
  int            m_sum;
  logic [2:0]    m_beats;
  logic          m_d1;
  logic          m_d2;
  logic [OB-1:0] m_res;

  function automatic int dot(input logic [CB*NC-1:0] a, input logic [CB*NC-1:0] w);
    int s = 0;
    for (int i = 0; i < NC; i++) s += $signed(a[i*CB +: CB]) * $signed(w[i*CB +: CB]);
    return s;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_acc <= 0; m_val <= 0; m_beats <= '0;
      m_d1 <= 1'b0; m_d2 <= 1'b0; m_res <= '0;
    end else begin
      m_d1 <= 1'b0;
      m_d2 <= m_d1;
      if (m_d1) m_res <= m_val[OB-1:0];
      if (pe_en) begin
        m_sum = m_acc + dot(pe_in, pe_weight);
        if (m_beats == pe_step) begin
          m_d1 <= 1'b1; m_val <= m_sum; m_acc <= 0; m_beats <= '0;
        end else begin
          m_acc <= m_sum; m_beats <= m_beats + 3'd1;
        end
      end
    end
  end

  assign pe_out    = m_res;
  assign pe_out_en = m_d2 | inj;

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [CB*NC-1:0] fill(input logic [CB-1:0] v);
    return {NC{v}};
  endfunction

  task automatic send_cmd(input logic [2:0] s, input logic [2:0] b);
    cmd_valid = 1'b1; cmd_step = s; cmd_bound = b;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [CB-1:0] c, input logic [CB-1:0] w);
    dat_valid = 1'b1; dat_in = fill(c); dat_weight = fill(w);
    tick();
    dat_valid = 1'b0;
  endtask

  // Wait (bounded) for res_valid; returns cycles waited.
  task automatic wait_res(input string tag, output int cyc);
    cyc = 0;
    while (!res_valid && cyc < 20) begin
      tick();
      cyc++;
    end
    check(tag, {31'd0, res_valid}, 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state
    #2;
    check("rst_cmd_ready", {31'd0, cmd_ready}, 1);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_pe_en", {31'd0, pe_en}, 0);
    check("rst_res_valid", {31'd0, res_valid}, 0);
    check("rst_err_stray", {31'd0, err_stray}, 0);
    check("rst_res_data", {24'd0, res_data}, 0);
    #10 reset = 1'b1;
    tick();

    // Single-beat job: step 0, all ones -> 9
    send_cmd(3'd0, 3'd0);
    check("j1_busy", {31'd0, busy}, 1);
    check("j1_cmd_ready", {31'd0, cmd_ready}, 0);
    check("j1_dat_ready", {31'd0, dat_ready}, 1);
    check("j1_pe_step", {29'd0, pe_step}, 0);
    send_beat(8'd1, 8'd1);
    check("j1_pe_en", {31'd0, pe_en}, 1);
    check("j1_wait_dat_ready", {31'd0, dat_ready}, 0);
    tick();
    check("j1_pe_en_drop", {31'd0, pe_en}, 0);
    wait_res("j1_res_timeout", lat);
    check("j1_latency", lat, 2);
    check("j1_res_data", {24'd0, res_data}, 9);
    // Hold RESP for 5 cycles, then release
    for (int i = 0; i < 5; i++) begin
      tick();
      check("j1_hold_valid", {31'd0, res_valid}, 1);
      check("j1_hold_data", {24'd0, res_data}, 9);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("j1_rel_valid", {31'd0, res_valid}, 0);
    check("j1_rel_cmd_ready", {31'd0, cmd_ready}, 1);
    check("j1_err_stray", {31'd0, err_stray}, 0);

    // Four beats with gaps, stray pulse in a gap; sum 18*(1+2+3+4)=180
    send_cmd(3'd3, 3'd5);
    check("j2_pe_step", {29'd0, pe_step}, 3);
    check("j2_pe_bound", {29'd0, pe_bound_level}, 5);
    for (int i = 0; i < 8; i++) begin
      dat_valid  = (i % 2 == 0);
      dat_in     = fill(8'(i / 2 + 1));
      dat_weight = fill(8'd2);
      inj        = (i == 3);
      tick();
      check("j2_pe_en", {31'd0, pe_en}, (i % 2 == 0) ? 1 : 0);
      check("j2_dat_ready", {31'd0, dat_ready}, (i < 6) ? 1 : 0);
      if (i == 3) check("j2_err_set", {31'd0, err_stray}, 1);
      if (i == 4) check("j2_pe_in_cell", {24'd0, pe_in[7:0]}, 3);
    end
    dat_valid = 1'b0;
    inj = 1'b0;
    wait_res("j2_res_timeout", lat);
    check("j2_res_data", {24'd0, res_data}, 180);
    check("j2_pe_step_hold", {29'd0, pe_step}, 3);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("j2_err_sticky", {31'd0, err_stray}, 1);

    // Job A then back-to-back job B with cmd_valid held through res_ready
    send_cmd(3'd0, 3'd2);
    check("ja_err_clear", {31'd0, err_stray}, 0);
    check("ja_pe_bound", {29'd0, pe_bound_level}, 2);
    send_beat(8'd1, 8'd3);
    wait_res("ja_res_timeout", lat);
    check("ja_res_data", {24'd0, res_data}, 27);
    cmd_valid = 1'b1; cmd_step = 3'd1; cmd_bound = 3'd6;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("jb_idle_cmd_ready", {31'd0, cmd_ready}, 1);
    check("jb_idle_res_valid", {31'd0, res_valid}, 0);
    tick();
    cmd_valid = 1'b0;
    check("jb_busy", {31'd0, busy}, 1);
    check("jb_pe_step", {29'd0, pe_step}, 1);
    check("jb_pe_bound", {29'd0, pe_bound_level}, 6);
    // Two beats of 2 * -1: -36 -> 8'hDC
    send_beat(8'd2, 8'hFF);
    send_beat(8'd2, 8'hFF);
    wait_res("jb_res_timeout", lat);
    check("jb_res_data", {24'd0, res_data}, 32'hDC);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;

    // Reset during beat 2 of a step-5 job
    send_cmd(3'd5, 3'd4);
    send_beat(8'd1, 8'd1);
    send_beat(8'd1, 8'd1);
    send_beat(8'd1, 8'd1);
    check("jr_pe_en_before", {31'd0, pe_en}, 1);
    #2 reset = 1'b0;
    #1;
    check("jr_pe_en_async", {31'd0, pe_en}, 0);
    check("jr_busy_async", {31'd0, busy}, 0);
    check("jr_pe_step_async", {29'd0, pe_step}, 0);
    #2 reset = 1'b1;
    @(posedge clk);
    #1;
    check("jr_cmd_ready", {31'd0, cmd_ready}, 1);
    check("jr_res_valid", {31'd0, res_valid}, 0);
    send_cmd(3'd1, 3'd1);
    send_beat(8'd1, 8'd1);
    send_beat(8'd1, 8'd1);
    wait_res("jr_res_timeout", lat);
    check("jr_res_data", {24'd0, res_data}, 18);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("jr_done_idle", {31'd0, cmd_ready}, 1);
    check("jr_no_stray", {31'd0, err_stray}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pe_feeder.md
PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 Parameter CELL_BIT, default 8, bits per cell.
REQ-002 Parameter N_CELL, default 9, cells per window beat.
REQ-003 Parameter OUT_BIT, default 8, PE result width.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low, ports named clk and reset.
REQ-005 Ports SHALL be as follows:
- clk  in  1  clock
- reset  in  1  async active-low reset
- cmd_valid  in  1  job request
- cmd_ready  out  1  job accepted
- cmd_step  in  3  beats per job minus 1
- cmd_bound  in  3  bound level for job
- dat_valid  in  1  window beat offered
- dat_ready  out  1  beat accepted
- dat_in  in  CELL_BIT*N_CELL  input cells
- dat_weight  in  CELL_BIT*N_CELL  weight cells
- pe_in  out  CELL_BIT*N_CELL  to PE in
- pe_weight  out  CELL_BIT*N_CELL  to PE weight
- pe_en  out  1  to PE en
- pe_step  out  3  to PE step
- pe_bound_level  out  3  to PE bound_level
- pe_out  in  OUT_BIT  from PE out
- pe_out_en  in  1  from PE out_en
- res_valid  out  1  result available
- res_ready  in  1  result taken
- res_data  out  OUT_BIT  signed result
- busy  out  1  state != IDLE
- err_stray  out  1  sticky stray pe_out_en flag

Function
REQ-006 The FSM SHALL have states IDLE, FEED, WAIT and RESP.
REQ-007 In IDLE: cmd_ready=1; on cmd_valid, latch cmd_step/cmd_bound, clear beat counter, clear err_stray, go to FEED.
REQ-008 In FEED: dat_ready=1; each dat_valid&dat_ready SHALL register dat_in/dat_weight into pe_in/pe_weight and assert pe_en for exactly the next cycle.
REQ-009 Cycles in FEED without an accepted beat SHALL drive pe_en=0; pe_in/pe_weight hold their last value.
REQ-010 The beat counter (3 bits) SHALL increment per accepted beat; the beat accepted with counter==latched step SHALL move the FSM to WAIT; exactly step+1 pe_en pulses per job.
REQ-011 pe_step and pe_bound_level SHALL equal the latched values, stable from the cycle after cmd acceptance until the return to IDLE.
REQ-012 In WAIT: dat_ready=0; on pe_out_en=1, capture pe_out into res_data, go to RESP.
REQ-013 Nominal latency: pe_out_en arrives 2 cycles after the final pe_en pulse; the block SHALL NOT time out and waits indefinitely.
REQ-014 In RESP: res_valid=1, res_data stable until res_ready; on res_ready go to IDLE, with res_valid low the next cycle.
REQ-015 cmd_ready SHALL be 1 only in IDLE, so a cmd_valid in the RESP handshake cycle is accepted no earlier than the following cycle.
REQ-016 pe_out_en in IDLE, FEED or RESP SHALL be ignored for data and SHALL set err_stray.
REQ-017 cmd_step=0 SHALL mean one beat, a single pe_en pulse; cmd_step=7 SHALL mean eight beats.
REQ-018 All outputs except cmd_ready, dat_ready and busy SHALL be registered; those three are decoded from state.

Reset
REQ-019 Reset asserted SHALL force IDLE and zero all registered outputs (pe_en, pe_in, pe_weight, pe_step, pe_bound_level, res_valid, res_data, err_stray, counter) immediately, independent of clk.
REQ-020 Reset mid-job SHALL drop the job with no result; the first clk edge after deassertion SHALL see IDLE with cmd_ready=1.

Structure
REQ-021 A shared package SHALL hold CELL_BIT, N_CELL, OUT_BIT, the FSM state encoding and the 3-bit step/bound widths, for reuse by PE_m integration.
REQ-022 The block SHALL be a single module with no sub-modules; it connects port-for-port to a PE_m instance sharing clk/reset.

Verification
REQ-023 cmd_step=0, cmd_bound=0, one beat with all cells 1 and weights 1, PE model -> one pe_en pulse, pe_step=0, res_data=9 two cycles later, res_valid held until res_ready.
REQ-024 cmd_step=3 with dat_valid toggled 1,0,1,0,... -> exactly 4 pe_en pulses, none in gap cycles, WAIT entered after the 4th beat.
REQ-025 RESP with res_ready=0 for 5 cycles, then 1 -> res_data constant for all 6 cycles, IDLE next, cmd_ready=1.
REQ-026 pe_out_en pulse injected during FEED -> err_stray=1, state and counter unchanged; next cmd acceptance clears err_stray.
REQ-027 Reset asserted during beat 2 of a cmd_step=5 job -> pe_en=0 and busy=0 asynchronously; new job after release completes normally.
REQ-028 Back-to-back jobs with cmd_valid held high through res_ready -> second job accepted the cycle after return to IDLE, with pe_step/pe_bound_level updated to the new values.
